// File: rtl/seq_gen.sv
// Serial pattern generator: sends a captured WIDTH-bit pattern MSB first, reps times
// back to back, over a valid/ready bit stream, then pulses done for one cycle.
module seq_gen #(
  parameter int              WIDTH           = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(4'b1010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       reps,
  input  logic             o_ready,
  output logic             o_bit,
  output logic             o_valid,
  output logic             o_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    bit_cnt, bit_cnt_d;
  logic [3:0]       rep_left, rep_left_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pat_q    <= DEFAULT_PATTERN;
      sh_q     <= DEFAULT_PATTERN;
      bit_cnt  <= '0;
      rep_left <= '0;
    end else begin
      state    <= state_d;
      pat_q    <= pat_d;
      sh_q     <= sh_d;
      bit_cnt  <= bit_cnt_d;
      rep_left <= rep_left_d;
    end
  end

  always_comb begin
    state_d    = state;
    pat_d      = pat_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt;
    rep_left_d = rep_left;
    case (state)
      IDLE: begin
        if (start && reps != 4'd0) begin
          pat_d      = pattern;
          sh_d       = pattern;
          rep_left_d = reps;
          bit_cnt_d  = CNT_MAX;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (o_ready) begin
          if (bit_cnt != '0) begin
            sh_d      = {sh_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt - 1'b1;
          end else if (rep_left > 4'd1) begin
            // reload in the same edge so repetitions stay gap-free
            sh_d       = pat_q;
            rep_left_d = rep_left - 4'd1;
            bit_cnt_d  = CNT_MAX;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // all outputs decode registered state only
  assign o_valid = (state == SEND);
  assign busy    = (state == SEND);
  assign o_bit   = (state == SEND) && sh_q[WIDTH-1];
  assign o_last  = (state == SEND) && (bit_cnt == '0) && (rep_left == 4'd1);
  assign done    = (state == DONE);

endmodule
